// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared widths, denominations, coin codes and FSM states.
package change_dispenser_pkg;
  localparam int AMT_W = 8;
  localparam logic [AMT_W-1:0] D0 = AMT_W'(1);
  localparam logic [AMT_W-1:0] D1 = AMT_W'(5);
  localparam logic [AMT_W-1:0] D2 = AMT_W'(10);
  localparam logic [AMT_W-1:0] D3 = AMT_W'(20);
  localparam logic [1:0] COIN_1 = 2'd0;
  localparam logic [1:0] COIN_5 = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, DONE, ERROR} state_t;
  function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] idx);
    return idx == COIN_20 ? D3 : idx == COIN_10 ? D2 : idx == COIN_5 ? D1 : D0;
  endfunction
endpackage

// File: rtl/change_dispenser_coin_select.sv
// coin_select: greedy largest-first pick among non-empty tubes that fit remain.
module coin_select
  import change_dispenser_pkg::*;
(
  input  logic [AMT_W-1:0] remain,
  input  logic [3:0]       coin_empty,
  output logic             found,
  output logic [1:0]       idx
);
  logic [3:0] ok;
  always_comb begin
    for (int i = 0; i < 4; i++) ok[i] = !coin_empty[i] && (coin_val(2'(i)) <= remain);
    found = |ok;
    idx = ok[3] ? COIN_20 : ok[2] ? COIN_10 : ok[1] ? COIN_5 : COIN_1;
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin per valid/ready handshake to the hopper.
module change_dispenser
  import change_dispenser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [3:0]       coin_empty,
  input  logic             hopper_ready,
  input  logic             clr,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remain,
  output logic [AMT_W-1:0] coin_cnt
);
  state_t state_q, state_d;
  logic coin_valid_q, coin_valid_d, done_q, done_d, err_q, err_d;
  logic [1:0] coin_type_q, coin_type_d;
  logic [AMT_W-1:0] remain_q, remain_d, coin_cnt_q, coin_cnt_d;
  logic found;
  logic [1:0] idx;

  coin_select u_sel (.remain(remain_q), .coin_empty(coin_empty), .found(found), .idx(idx));

  always_comb begin
    state_d = state_q;
    coin_valid_d = coin_valid_q;
    coin_type_d = coin_type_q;
    done_d = 1'b0;
    err_d = err_q;
    remain_d = remain_q;
    coin_cnt_d = coin_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        remain_d = amount;
        coin_cnt_d = '0;
        state_d = SELECT;
      end
      SELECT: if (remain_q == '0) begin
        done_d = 1'b1;
        state_d = DONE;
      end else if (found) begin
        coin_type_d = idx;
        coin_valid_d = 1'b1;
        state_d = OFFER;
      end else begin
        err_d = 1'b1;
        state_d = ERROR;
      end
      // selection guaranteed the coin fits, so this cannot underflow
      OFFER: if (hopper_ready) begin
        remain_d = remain_q - coin_val(coin_type_q);
        coin_cnt_d = coin_cnt_q + 1'b1;
        coin_valid_d = 1'b0;
        state_d = SELECT;
      end
      DONE: state_d = IDLE;
      ERROR: if (clr) begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      coin_valid_q <= 1'b0;
      coin_type_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      remain_q <= '0;
      coin_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q <= coin_type_d;
      done_q <= done_d;
      err_q <= err_d;
      remain_q <= remain_d;
      coin_cnt_q <= coin_cnt_d;
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_type = coin_type_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign remain = remain_q;
  assign coin_cnt = coin_cnt_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of greedy payout, stalls, errors and reset.
module tb_change_dispenser;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hopper_ready = 1'b1, clr = 1'b0;
  logic [7:0] amount = '0;
  logic [3:0] coin_empty = '0;
  logic coin_valid, busy, done, err;
  logic [1:0] coin_type;
  logic [7:0] remain, coin_cnt;
  int total = 0, bad = 0;
  int seq, len, end_cyc;

  change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .coin_empty(coin_empty),
    .hopper_ready(hopper_ready), .clr(clr), .coin_valid(coin_valid), .coin_type(coin_type),
    .busy(busy), .done(done), .err(err), .remain(remain), .coin_cnt(coin_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle start is high; seq packs handed-over coin types base 4.
  task automatic run_txn(input logic [7:0] amt, input int inj);
    seq = 0;
    len = 0;
    end_cyc = -1;
    amount = amt;
    start = 1'b1;
    tick();
    start = 1'b0;
    amount = '0;
    for (int c = 1; c <= 100; c++) begin
      if (coin_valid && hopper_ready) begin
        seq = seq * 4 + int'(coin_type);
        len++;
      end
      if (done || err) begin
        end_cyc = c;
        break;
      end
      start = (c == inj);
      amount = (c == inj) ? 8'd99 : 8'd0;
      tick();
    end
    start = 1'b0;
    amount = '0;
  endtask

  initial begin
    #1;
    chk("rst_valid", coin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remain", remain, 0);
    chk("rst_cnt", coin_cnt, 0);
    #11 rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    // 37 = 20+10+5+1+1
    run_txn(8'd37, -1);
    chk("t1_seq", seq, 912);
    chk("t1_len", len, 5);
    chk("t1_done_cyc", end_cyc, 12);
    chk("t1_cnt", coin_cnt, 5);
    chk("t1_remain", remain, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_cnt_kept", coin_cnt, 5);
    // zero amount pays nothing
    run_txn(8'd0, -1);
    chk("t2_len", len, 0);
    chk("t2_done_cyc", end_cyc, 2);
    chk("t2_cnt", coin_cnt, 0);
    tick();
    chk("t2_busy_after", busy, 0);
    chk("t2_done_pulse", done, 0);
    // stalled offer holds coin_type even when its tube reports empty
    hopper_ready = 1'b0;
    amount = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_select_valid", coin_valid, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_valid", coin_valid, 1);
      chk("t3_hold_type", coin_type, 1);
      chk("t3_hold_cnt", coin_cnt, 0);
      coin_empty = coin_empty ^ 4'b0010;
      tick();
    end
    chk("t3_still_valid", coin_valid, 1);
    chk("t3_still_type", coin_type, 1);
    coin_empty = '0;
    hopper_ready = 1'b1;
    tick();
    chk("t3_after_hs_valid", coin_valid, 0);
    chk("t3_after_hs_remain", remain, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_cnt", coin_cnt, 1);
    tick();
    // no 20s: four 10s
    coin_empty = 4'b1000;
    run_txn(8'd40, -1);
    chk("t4_seq", seq, 170);
    chk("t4_len", len, 4);
    chk("t4_done_cyc", end_cyc, 10);
    chk("t4_cnt", coin_cnt, 4);
    tick();
    // no 1s: 7 leaves a shortfall of 2
    coin_empty = 4'b0001;
    run_txn(8'd7, -1);
    chk("t5_seq", seq, 1);
    chk("t5_len", len, 1);
    chk("t5_err_cyc", end_cyc, 4);
    chk("t5_err", err, 1);
    chk("t5_remain", remain, 2);
    chk("t5_done", done, 0);
    amount = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    amount = '0;
    chk("t5_start_ign_err", err, 1);
    chk("t5_start_ign_rem", remain, 2);
    chk("t5_start_ign_busy", busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_err", err, 0);
    chk("t5_clr_busy", busy, 0);
    chk("t5_clr_remain", remain, 2);
    coin_empty = '0;
    // reset in the middle of an offer
    amount = 8'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_offer_valid", coin_valid, 1);
    chk("t6_offer_type", coin_type, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", coin_valid, 0);
    chk("t6_rst_type", coin_type, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_remain", remain, 0);
    chk("t6_rst_cnt", coin_cnt, 0);
    #2 rst = 1'b0;
    tick();
    chk("t6_post_rst_busy", busy, 0);
    // a start mid-transaction is dropped; 30 = 20+10 still completes
    run_txn(8'd30, 3);
    chk("t6_seq", seq, 14);
    chk("t6_len", len, 2);
    chk("t6_done_cyc", end_cyc, 6);
    chk("t6_cnt", coin_cnt, 2);
    chk("t6_remain", remain, 0);
    tick();
    chk("t6_busy_after", busy, 0);
    chk("t6_remain_after", remain, 0);
    // clr outside ERROR does nothing
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t7_clr_idle_busy", busy, 0);
    chk("t7_clr_idle_cnt", coin_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
